// File: rtl/current_setpoint_ctrl_if.sv
// ----------------------------------------------------------------------------
// current_setpoint_ctrl_if
// Groups the button, preset-load and setpoint signals of current_setpoint_ctrl.
// The master side (UI / test driver) drives the requests. The slave side (the
// setpoint controller) drives q and the status flags.
// ----------------------------------------------------------------------------
interface current_setpoint_ctrl_if #(
  parameter int WIDTH = 5
);

  logic             en;        // 1 = button stepping allowed
  logic             btn_up;    // increment request, level (held = auto-repeat)
  logic             btn_down;  // decrement request, level
  logic             load;      // 1-cycle strobe: q <= clamp(load_val)
  logic [WIDTH-1:0] load_val;  // preset value
  logic [WIDTH-1:0] q;         // current setpoint index
  logic             at_min;    // q == MIN_VAL
  logic             at_max;    // q == MAX_VAL
  logic             changed;   // 1-cycle pulse after q changed value

  modport master (
    output en, btn_up, btn_down, load, load_val,
    input  q, at_min, at_max, changed
  );

  modport slave (
    input  en, btn_up, btn_down, load, load_val,
    output q, at_min, at_max, changed
  );

endinterface

// File: rtl/current_setpoint_ctrl.sv
// ----------------------------------------------------------------------------
// current_setpoint_ctrl
// Holds the user-selected PWM current index. This is the parametrised successor
// of the 5-bit current-select up/down counter.
//   - up/down buttons step q by STEP and saturate at MIN_VAL / MAX_VAL
//   - a held button auto-repeats: the first repeat step comes HOLD_CYCLES after
//     the press, later steps come every REPEAT_CYCLES
//   - load presets q to load_val, clamped into [MIN_VAL, MAX_VAL]
//   - at_min / at_max decode q; changed pulses the cycle after q moves
// Buttons are synchronous to clk and debounced upstream.
// Build option: define SETPOINT_WRAP_EN to make button steps wrap around
// (MAX_VAL -> MIN_VAL and back) instead of saturating. Load still clamps.
// ----------------------------------------------------------------------------
module current_setpoint_ctrl #(
  parameter int WIDTH         = 5,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 31,
  parameter int RESET_VAL     = 0,
  parameter int STEP          = 1,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,   // asynchronous, active-low
  current_setpoint_ctrl_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,  // waiting for a clean press edge
    S_HOLD     = 2'd1,  // button held, waiting for the first auto-repeat
    S_REPEAT   = 2'd2,  // button held, auto-repeating
    S_WAIT_REL = 2'd3   // ignore buttons until both are released
  } state_e;

  localparam logic [WIDTH-1:0] LP_MIN   = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LP_MAX   = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LP_RESET = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LP_STEP  = STEP[WIDTH-1:0];

  // Step limits are compared one bit wider so q+STEP cannot wrap silently.
  localparam logic [WIDTH:0] LP_MAX_X    = {1'b0, LP_MAX};
  localparam logic [WIDTH:0] LP_STEP_X   = {1'b0, LP_STEP};
  localparam logic [WIDTH:0] LP_DN_LIMIT = {1'b0, LP_MIN} + LP_STEP_X;

  // The repeat timer only has to count up to the longer of the two intervals.
  localparam int TMR_SPAN = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                          : REPEAT_CYCLES;
  localparam int TW       = (TMR_SPAN > 1) ? $clog2(TMR_SPAN) : 1;

  localparam logic [TW-1:0] LP_HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LP_REP_LAST  = TW'(REPEAT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  state_e           r_state;
  logic [TW-1:0]    r_timer;
  logic             r_dir_up;   // direction of the button being held
  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic             r_up_d;     // button levels at the previous edge
  logic             r_dn_d;

  state_e           w_state_nxt;
  logic [TW-1:0]    w_timer_nxt;
  logic             w_dir_nxt;
  logic             w_step;     // apply one step at this edge
  logic             w_step_up;  // direction of that step
  logic [WIDTH-1:0] w_q_nxt;

  logic             w_up_edge;
  logic             w_dn_edge;
  logic             w_held;     // the button that started this hold is still down
  logic             w_other;    // the opposite button is down

  logic [WIDTH:0]   w_sum_x;
  logic [WIDTH-1:0] w_q_up;
  logic [WIDTH-1:0] w_q_dn;
  logic [WIDTH-1:0] w_q_load;

  assign w_up_edge = bus.btn_up   & ~r_up_d;
  assign w_dn_edge = bus.btn_down & ~r_dn_d;
  assign w_held    = r_dir_up ? bus.btn_up   : bus.btn_down;
  assign w_other   = r_dir_up ? bus.btn_down : bus.btn_up;

  // --------------------------------------------------------------------------
  // State register: FSM, repeat timer, setpoint, change pulse, button history
  // --------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // values from before the edge, whatever order the statements are listed in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_dir_up  <= 1'b0;
      r_q       <= LP_RESET;
      r_changed <= 1'b0;
      r_up_d    <= 1'b0;
      r_dn_d    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_dir_up  <= w_dir_nxt;
      r_q       <= w_q_nxt;
      r_changed <= (w_q_nxt != r_q);
      r_up_d    <= bus.btn_up;
      r_dn_d    <= bus.btn_down;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: press detection, hold / repeat timing, release tracking
  // --------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the branches, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dir_nxt   = r_dir_up;
    w_step      = 1'b0;
    w_step_up   = r_dir_up;

    if (bus.load) begin
      // A preset overrides the buttons, and a button still held must be
      // released before it can step again.
      w_state_nxt = S_WAIT_REL;
      w_timer_nxt = '0;
    end else if (!bus.en) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.btn_up && bus.btn_down) begin
            w_state_nxt = S_WAIT_REL;
          end else if (w_up_edge) begin
            w_step      = 1'b1;
            w_step_up   = 1'b1;
            w_dir_nxt   = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = S_HOLD;
          end else if (w_dn_edge) begin
            w_step      = 1'b1;
            w_step_up   = 1'b0;
            w_dir_nxt   = 1'b0;
            w_timer_nxt = '0;
            w_state_nxt = S_HOLD;
          end
        end

        S_HOLD, S_REPEAT: begin
          if (w_other) begin
            w_state_nxt = S_WAIT_REL;
            w_timer_nxt = '0;
          end else if (!w_held) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
          end else if (r_timer == ((r_state == S_HOLD) ? LP_HOLD_LAST
                                                       : LP_REP_LAST)) begin
            // A step at a limit still counts as a repeat, so the timer keeps
            // running even when q cannot move.
            w_step      = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = S_REPEAT;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end

        S_WAIT_REL: begin
          w_timer_nxt = '0;
          if (!bus.btn_up && !bus.btn_down) begin
            w_state_nxt = S_IDLE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: step arithmetic, load clamp, next setpoint
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum_x = {1'b0, r_q} + LP_STEP_X;

`ifdef SETPOINT_WRAP_EN
    w_q_up = (w_sum_x > LP_MAX_X) ? LP_MIN : w_sum_x[WIDTH-1:0];
    w_q_dn = ({1'b0, r_q} < LP_DN_LIMIT) ? LP_MAX : (r_q - LP_STEP);
`else
    w_q_up = (w_sum_x > LP_MAX_X) ? LP_MAX : w_sum_x[WIDTH-1:0];
    w_q_dn = ({1'b0, r_q} < LP_DN_LIMIT) ? LP_MIN : (r_q - LP_STEP);
`endif

    if (bus.load_val > LP_MAX) begin
      w_q_load = LP_MAX;
    end else if (bus.load_val < LP_MIN) begin
      w_q_load = LP_MIN;
    end else begin
      w_q_load = bus.load_val;
    end

    w_q_nxt = r_q;
    if (bus.load) begin
      w_q_nxt = w_q_load;
    end else if (w_step) begin
      w_q_nxt = w_step_up ? w_q_up : w_q_dn;
    end
  end

  assign bus.q       = r_q;
  assign bus.at_min  = (r_q == LP_MIN);
  assign bus.at_max  = (r_q == LP_MAX);
  assign bus.changed = r_changed;

endmodule
